// File: rtl/ysyx_dmem_responder.sv
// LSU-facing SRAM responder: one read or write at a time, one-cycle rvalid/wready completion pulse.
// Latency LATENCY cycles (LATENCY..LATENCY+3 with YSYX_DMEM_RANDLAT_EN); inputs ignored outside IDLE.
module ysyx_dmem_responder #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h80000000,
    parameter int                LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready
);

    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam int                NB        = DATA_W / 8;
    localparam int                LANE_W    = $clog2(NB);
    localparam int                CNT_W     = $clog2(LATENCY + 4);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_WAIT,
        S_WR_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_dec;
    logic [CNT_W-1:0]    w_lat_m1;
    logic                w_acc_rd;
    logic                w_acc_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NB-1:0]       r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   w_off;
    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic [LANE_W-1:0]   w_lane;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wdata_sh;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_unused;
    logic [DATA_W-1:0]   r_mem [MEM_WORDS];

`ifdef YSYX_DMEM_RANDLAT_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; its low two bits stretch the latency of the access being accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_lat_m1 = CNT_W'(LATENCY - 1) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_lat_m1 = CNT_W'(LATENCY - 1);
`endif

    assign w_cnt_dec  = r_cnt - CNT_W'(1);
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = (w_off < MEM_BYTES);
    assign w_idx      = w_off[IDX_W+LANE_W-1:LANE_W];
    assign w_lane     = w_off[LANE_W-1:0];
    // Lane shift truncates at the word edge: bytes pushed past the top lane are dropped, never wrapped
    assign w_be       = r_wstrb << w_lane;
    assign w_wdata_sh = r_wdata << {w_lane, 3'b000};
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;
    assign w_unused   = ^{lsu_rstrb, lsu_wstrb[7:NB]};

    always_comb begin
        w_state_nxt = r_state;
        w_acc_rd    = 1'b0;
        w_acc_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lsu_awvalid && lsu_wvalid) begin
                    w_acc_wr    = 1'b1;
                    w_state_nxt = (w_lat_m1 == '0) ? S_WR_RESP : S_WR_WAIT;
                end else if (lsu_arvalid) begin
                    w_acc_rd    = 1'b1;
                    w_state_nxt = (w_lat_m1 == '0) ? S_RD_RESP : S_RD_WAIT;
                end
            end
            S_RD_WAIT: if (w_cnt_dec == '0) w_state_nxt = S_RD_RESP;
            S_WR_WAIT: if (w_cnt_dec == '0) w_state_nxt = S_WR_RESP;
            S_RD_RESP: w_state_nxt = S_IDLE;
            S_WR_RESP: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc_rd || w_acc_wr) begin
                r_cnt <= w_lat_m1;
            end else if (r_state == S_RD_WAIT || r_state == S_WR_WAIT) begin
                r_cnt <= w_cnt_dec;
            end
            if (r_state == S_RD_RESP) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // Request copies and SRAM are not reset; the write lands at the end of the WR_RESP cycle
    always_ff @(posedge clk) begin
        if (w_acc_wr) begin
            r_addr  <= lsu_awaddr;
            r_wdata <= lsu_wdata;
            r_wstrb <= lsu_wstrb[NB-1:0];
        end else if (w_acc_rd) begin
            r_addr <= lsu_araddr;
        end
        if (!rst && r_state == S_WR_RESP && w_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign lsu_rvalid = (r_state == S_RD_RESP);
    assign lsu_wready = (r_state == S_WR_RESP);
    // The response word is live during RD_RESP and then held until the next read response
    assign lsu_rdata  = (r_state == S_RD_RESP) ? w_rd_word : r_rdata;

endmodule

// File: tb/tb_ysyx_dmem_responder.sv
// Bench for ysyx_dmem_responder: directed loads/stores, a driver that queues expected responses
// and a monitor that checks every rvalid/wready pulse against that queue.
module tb_ysyx_dmem_responder;

    localparam int LAT = 2;
`ifdef YSYX_DMEM_RANDLAT_EN
    localparam int LAT_MAX = LAT + 3;
`else
    localparam int LAT_MAX = LAT;
`endif

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic [7:0]  lsu_rstrb = '0;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr = '0;
    logic        lsu_awvalid = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [7:0]  lsu_wstrb = '0;
    logic        lsu_wvalid = 1'b0;
    logic        lsu_wready;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl [8];

    ysyx_dmem_responder #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .BASE_ADDR(32'h80000000), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   prev = 1'b0;
        bit   pr;
        bit   pw;
        int   lat;
        forever begin
            @(negedge clk);
            pr = (lsu_rvalid === 1'b1);
            pw = (lsu_wready === 1'b1);
            if (pr || pw) begin
                chk("pulse_exclusive", {31'b0, pr & pw}, 32'd0);
                chk("pulse_single_cycle", {31'b0, prev}, 32'd0);
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_pulse: got rvalid=%b wready=%b expected no response", pr, pw);
                end else begin
                    e = sb.pop_front();
                    chk("resp_kind_is_read", {31'b0, pr}, {31'b0, e.is_rd});
                    lat = cyc - e.cyc;
                    n_checks++;
                    if (lat < LAT || lat > LAT_MAX) begin
                        n_errors++;
                        $display("FAIL latency: got %0d expected %0d..%0d", lat, LAT, LAT_MAX);
                    end
                    if (e.is_rd) chk("rdata", lsu_rdata, e.data);
                end
            end
            prev = pr | pw;
        end
    endtask

    task automatic issue(input bit is_rd, input logic [31:0] addr, input logic [31:0] data,
                         input logic [7:0] strb, input logic [31:0] exp_rd);
        exp_t e;
        bit   got = 1'b0;
        int   n = 0;
        @(posedge clk);
        #1;
        if (is_rd) begin
            lsu_araddr  = addr;
            lsu_rstrb   = strb;
            lsu_arvalid = 1'b1;
        end else begin
            lsu_awaddr  = addr;
            lsu_wdata   = data;
            lsu_wstrb   = strb;
            lsu_awvalid = 1'b1;
            lsu_wvalid  = 1'b1;
        end
        e.is_rd = is_rd;
        e.data  = exp_rd;
        e.cyc   = cyc;
        sb.push_back(e);
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = is_rd ? (lsu_rvalid === 1'b1) : (lsu_wready === 1'b1);
        end
        if (!got) begin
            chk("response_timeout", {31'b0, got}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        lsu_arvalid = 1'b0;
        lsu_awvalid = 1'b0;
        lsu_wvalid  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb);
        issue(1'b0, addr, data, strb, 32'h0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd);
        issue(1'b1, addr, 32'h0, 8'h0f, exp_rd);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_rvalid", {31'b0, lsu_rvalid}, 32'd0);
            chk("idle_wready", {31'b0, lsu_wready}, 32'd0);
            chk("idle_rdata", lsu_rdata, 32'h0);
        end

        wr(32'h80000010, 32'h11223344, 8'h0f);
        rd(32'h80000010, 32'h11223344);
        wr(32'h80000013, 32'h000000AB, 8'h01);
        rd(32'h80000010, 32'hAB223344);
        wr(32'h80000013, 32'h0000CDEF, 8'h03);
        rd(32'h80000013, 32'hEF223344);
        wr(32'h80000012, 32'h0000BEEF, 8'h03);
        rd(32'h80000010, 32'hBEEF3344);
        wr(32'h80000011, 32'h0000005A, 8'h01);
        rd(32'h80000010, 32'hBEEF5A44);

        // halfword straddling the word edge: upper byte must not spill into the next word
        wr(32'h80000030, 32'hAAAAAAAA, 8'h0f);
        wr(32'h80000034, 32'hBBBBBBBB, 8'h0f);
        wr(32'h80000033, 32'h000077CC, 8'h03);
        rd(32'h80000030, 32'hCCAAAAAA);
        rd(32'h80000034, 32'hBBBBBBBB);

        wr(32'h80000000, 32'hCAFEF00D, 8'h0f);
        wr(32'h80000FFC, 32'h0BADF00D, 8'h0f);
        rd(32'h80000FFC, 32'h0BADF00D);
        rd(32'h00001000, 32'h00000000);
        wr(32'h00001000, 32'hDEADBEEF, 8'h0f);
        rd(32'h80001000, 32'h00000000);
        wr(32'h80001000, 32'hFEEDFACE, 8'h0f);
        rd(32'h80000000, 32'hCAFEF00D);
        wr(32'h80000040, 32'h00000000, 8'h0f);
        @(negedge clk);
        chk("rdata_hold", lsu_rdata, 32'hCAFEF00D);

        // reset while the read is waiting: no rvalid may follow
        @(posedge clk);
        #1;
        lsu_araddr  = 32'h80000010;
        lsu_arvalid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lsu_arvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_rd_no_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        end
        rd(32'h80000010, 32'hBEEF5A44);

        // reset while the write is waiting: old contents must survive
        wr(32'h80000020, 32'h12345678, 8'h0f);
        @(posedge clk);
        #1;
        lsu_awaddr  = 32'h80000020;
        lsu_wdata   = 32'h99999999;
        lsu_wstrb   = 8'h0f;
        lsu_awvalid = 1'b1;
        lsu_wvalid  = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lsu_awvalid = 1'b0;
        lsu_wvalid  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_wr_no_wready", {31'b0, lsu_wready}, 32'd0);
        end
        rd(32'h80000020, 32'h12345678);

        // 100 mixed accesses over eight words
        for (int i = 0; i < 50; i++) begin
            int          wi;
            int          ri;
            logic [31:0] d;
            wi = i % 8;
            d  = {i[7:0], ~i[7:0], i[7:0] + 8'h5A, 8'hC3};
            wr(32'h80000200 + 32'(wi * 4), d, 8'h0f);
            mdl[wi] = d;
            ri = (i >= 7) ? ((i * 5) % 8) : wi;
            rd(32'h80000200 + 32'(ri * 4), mdl[ri]);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_dmem_responder.md
# ysyx_dmem_responder

Memory-side responder for the LSU load/store bus: accepts one read (`lsu_araddr`/`lsu_arvalid`/`lsu_rstrb`) or one write (`lsu_awaddr`/`lsu_awvalid`/`lsu_wdata`/`lsu_wstrb`/`lsu_wvalid`) at a time. Each access is served from an internal word-organised SRAM model after a programmable latency, and completion is signalled with a one-cycle `lsu_rvalid` / `lsu_wready` pulse. It sits where the system bus/SRAM would be, in NPC simulation and in LSU/L1D unit benches.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (word = 4 bytes)
- `MEM_WORDS`, 1024, SRAM depth in words (power of two)
- `BASE_ADDR`, 32'h80000000, byte address of word 0
- `LATENCY`, 2, cycles from request acceptance to response pulse (≥1)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `lsu_araddr` in ADDR_W: read byte address
- `lsu_arvalid` in 1: read request
- `lsu_rstrb` in 8: read byte strobe (1/3/f); informational only
- `lsu_rdata` out DATA_W: full aligned word, unshifted
- `lsu_rvalid` out 1: read response pulse
- `lsu_awaddr` in ADDR_W: write byte address
- `lsu_awvalid` in 1: write address valid
- `lsu_wdata` in DATA_W: write data, LSB-justified (not lane-shifted)
- `lsu_wstrb` in 8: write strobe, LSB-justified (1/3/f)
- `lsu_wvalid` in 1: write data valid
- `lsu_wready` out 1: write completion pulse

## Operation
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- IDLE:
  - `lsu_awvalid & lsu_wvalid` → latch awaddr/wdata/wstrb, go WR_WAIT.
  - Else `lsu_arvalid` → latch araddr, go RD_WAIT.
  - Write wins if both are present.
- Latency:
  - On acceptance, down-counter `cnt` (width $clog2(LATENCY+4)) loads `LATENCY-1`.
  - RD_WAIT/WR_WAIT decrement `cnt`; at `cnt==0` go to the RESP state.
  - If `LATENCY==1`, acceptance goes directly to the RESP state.
- RD_RESP: `lsu_rvalid=1` for exactly one cycle; then go IDLE.
- WR_RESP: `lsu_wready=1` for exactly one cycle; then go IDLE.
- Address decode:
  - `off = addr - BASE_ADDR`; in range iff `off < MEM_WORDS*4`.
  - Word index `off[$clog2(MEM_WORDS)+1:2]`; lane `l = addr[1:0]`.
- Read: `lsu_rdata = mem[idx]` (whole word; the LSU does the shift and extension). Out of range → `lsu_rdata = 0`.
- Write:
  - Effective byte enable `be = (wstrb << l)[3:0]`; effective data `wdata << (8*l)`.
  - Bytes shifted beyond lane 3 are dropped (no wrap to the next word).
  - The write commits to `mem` in the WR_RESP cycle.
  - Out of range: write dropped, `lsu_wready` still pulses.
- `lsu_rdata` holds its last value until the next RD_RESP.
- Initiator contract: requests stay asserted until their response pulse and deassert the cycle after it. A request still asserted in IDLE is treated as a new access.
- `rst` clears FSM, `cnt` and outputs. SRAM contents are not reset.

## Timing
- Reset values: `lsu_rvalid=0`, `lsu_wready=0`, `lsu_rdata=0`; state IDLE.
- Request sampled in IDLE at edge t → response pulse visible in cycle t+LATENCY.
- Back-to-back accesses: LATENCY+1 cycles per access (IDLE cycle between).
- Inputs are ignored outside IDLE; changes mid-access have no effect (latched copies are used).
- `rst` during WAIT/RESP: access aborted, no pulse on the next cycle, pending write not committed, state IDLE.
- Read following write to the same word sees the new data (commit precedes the next IDLE acceptance).

## Configuration
- `YSYX_DMEM_RANDLAT_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - Each accepted access uses latency `LATENCY + lfsr[1:0]` (range LATENCY..LATENCY+3).
  - The LFSR value is sampled at acceptance.
- Undefined: no LFSR; latency fixed at `LATENCY`.

## Test plan
- Reset, then idle 5 cycles → `lsu_rvalid`, `lsu_wready` and `lsu_rdata` stay 0.
- SW 0x80000010 data 0x11223344 wstrb f, then LW 0x80000010 (LATENCY=2) → `wready` pulses 2 cycles after acceptance; `rdata=0x11223344` with `rvalid` 2 cycles after read acceptance.
- SB 0x80000013 data 0x000000AB wstrb 1, then LW 0x80000010 → `rdata=0xAB223344`. SH at 0x80000013 data 0xCDEF → only byte 3 = 0xEF written.
- LW 0x00001000 (out of range) → `rvalid` pulses, `rdata=0`. SW there → `wready` pulses, SRAM unchanged.
- Assert `rst` in RD_WAIT → no `rvalid` follows; next LW completes normally after LATENCY.
- With `YSYX_DMEM_RANDLAT_EN`, 100 random loads/stores → every latency in [2,5], every response single-cycle, data matches the scoreboard.
